// File: rtl/vram_pkg.sv
// Shared VRAM definitions: geometry of the text screen, word types and the
// port-A arbiter state encoding.
package vram_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;
  localparam int TEXT_COLS   = 60;
  localparam int TEXT_ROWS   = 17;

  localparam logic [VRAM_DATA_W-1:0] BLANK_CHAR = 8'h20;

  typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
  typedef logic [VRAM_DATA_W-1:0] vram_data_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_clear_seq.sv
// Screen-clear sequencer: walks addresses 0..CLEAR_WORDS-1 while the arbiter
// is in CLEAR. The counter has one extra bit so a full 2^ADDR_W clear ends on
// its terminal count instead of wrapping back to zero.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int CLEAR_WORDS = TEXT_COLS * TEXT_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLEAR_WORDS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  assign done = active && (count_q == LAST_CNT);
  assign addr = count_q[ADDR_W-1:0];
  assign busy = busy_q;

  // Restart from zero on start, step once per clear cycle, drop busy at the end.
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (start) begin
      count_d = '0;
      busy_d  = 1'b1;
    end else if (active) begin
      if (done) begin
        count_d = '0;
        busy_d  = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Counter and busy registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM port-A write arbiter: round-robin between the CPU (req0) and a bulk
// writer (req1), with registered port-A outputs. The screen-clear sequencer
// is compiled in only when VRAM_ARB_CLEAR_EN is defined.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int               ADDR_W      = VRAM_ADDR_W,
  parameter int               DATA_W      = VRAM_DATA_W,
  parameter int               CLEAR_WORDS = TEXT_COLS * TEXT_ROWS,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(BLANK_CHAR)
) (
  input  logic              MEMORY_CLK,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              v_cea,
  output logic [ADDR_W-1:0] v_ada,
  output logic [DATA_W-1:0] v_din
);

  logic              arb_en;
  logic              clear_active;
  logic [ADDR_W-1:0] clear_addr;
  logic              grant0, grant1;
  logic              last_grant_q, last_grant_d;
  logic              v_cea_q, v_cea_d;
  logic [ADDR_W-1:0] v_ada_q, v_ada_d;
  logic [DATA_W-1:0] v_din_q, v_din_d;

`ifdef VRAM_ARB_CLEAR_EN
  arb_state_e state_q, state_d;
  logic       clear_done;

  assign arb_en       = (state_q == ARB);
  assign clear_active = (state_q == CLEAR);

  vram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_clear_seq (
    .clk    (MEMORY_CLK),
    .rst_n  (rst_n),
    .start  (arb_en && clear_start),
    .active (clear_active),
    .addr   (clear_addr),
    .busy   (clear_busy),
    .done   (clear_done)
  );

  // Enter CLEAR on a start pulse seen in ARB; return once the last cell is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (clear_start) state_d = CLEAR;
      CLEAR:   if (clear_done)  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end
`else
  logic clear_cfg_unused;

  assign arb_en           = 1'b1;
  assign clear_active     = 1'b0;
  assign clear_addr       = '0;
  assign clear_busy       = 1'b0;
  assign clear_cfg_unused = clear_start | (CLEAR_WORDS == 0);
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Sole requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant0       = arb_en && req0_valid && (!req1_valid || last_grant_q);
    grant1       = arb_en && req1_valid && (!req0_valid || !last_grant_q);
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;
  end

  // Select the next port-A write: clear cell, granted request, or hold.
  always_comb begin
    v_cea_d = 1'b0;
    v_ada_d = v_ada_q;
    v_din_d = v_din_q;
    if (clear_active) begin
      v_cea_d = 1'b1;
      v_ada_d = clear_addr;
      v_din_d = CLEAR_CHAR;
    end else if (grant0) begin
      v_cea_d = 1'b1;
      v_ada_d = req0_addr;
      v_din_d = req0_data;
    end else if (grant1) begin
      v_cea_d = 1'b1;
      v_ada_d = req1_addr;
      v_din_d = req1_data;
    end
  end

  // Port-A output registers and round-robin pointer.
  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      v_cea_q      <= 1'b0;
      v_ada_q      <= '0;
      v_din_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      v_cea_q      <= v_cea_d;
      v_ada_q      <= v_ada_d;
      v_din_q      <= v_din_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign v_cea = v_cea_q;
  assign v_ada = v_ada_q;
  assign v_din = v_din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter. Random and directed traffic is
// compared against a cycle-level reference model of the arbitration rules.
// Clear-sequencer scenarios are built when VRAM_ARB_CLEAR_EN is defined.
module tb_vram_write_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int WORDS = 1020;

  logic          MEMORY_CLK = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          clear_start, clear_busy;
  logic          v_cea;
  logic [AW-1:0] v_ada;
  logic [DW-1:0] v_din;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  int            mLast;
  int            mClearLeft;
  int            mClearAddr;
  logic          mCea;
  logic [AW-1:0] mAda;
  logic [DW-1:0] mDin;
  logic          mBusy;
  int            lastWinner;
  int            pulsesIgnored = 0;

  vram_write_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .CLEAR_WORDS (WORDS),
    .CLEAR_CHAR  (8'h20)
  ) dut (
    .MEMORY_CLK  (MEMORY_CLK),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .v_cea       (v_cea),
    .v_ada       (v_ada),
    .v_din       (v_din)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLast      = 1;
    mClearLeft = 0;
    mClearAddr = 0;
    mCea       = 1'b0;
    mAda       = '0;
    mDin       = '0;
    mBusy      = 1'b0;
    lastWinner = -1;
  endtask

  // Requester index that should be accepted this cycle, or -1.
  function automatic int pickWinner(input logic v0, input logic v1);
    if (mClearLeft > 0) return -1;
    if (v0 && v1)       return (mLast == 0) ? 1 : 0;
    if (v0)             return 0;
    if (v1)             return 1;
    return -1;
  endfunction

  // One clock cycle: drive inputs, check readys, advance the model, check outputs.
  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic cs);
    int w;
    req0_valid  = v0;
    req0_addr   = a0;
    req0_data   = d0;
    req1_valid  = v1;
    req1_addr   = a1;
    req1_data   = d1;
    clear_start = cs;
    @(negedge MEMORY_CLK);
    w = pickWinner(v0, v1);
    checkOutput("req0_ready", 32'(req0_ready), 32'(w == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(w == 1));
    @(posedge MEMORY_CLK);
    #1;
    if (mClearLeft > 0) begin
      mCea = 1'b1;
      mAda = AW'(mClearAddr);
      mDin = 8'h20;
      mClearAddr++;
      mClearLeft--;
    end else begin
      mCea = 1'b0;
      if (w == 0) begin
        mCea = 1'b1; mAda = a0; mDin = d0; mLast = 0;
      end else if (w == 1) begin
        mCea = 1'b1; mAda = a1; mDin = d1; mLast = 1;
      end
`ifdef VRAM_ARB_CLEAR_EN
      if (cs) begin
        mClearLeft = WORDS;
        mClearAddr = 0;
      end
`else
      if (cs) pulsesIgnored++;
`endif
    end
    mBusy      = (mClearLeft > 0);
    lastWinner = w;
    checkOutput("v_cea", 32'(v_cea), 32'(mCea));
    checkOutput("v_ada", 32'(v_ada), 32'(mAda));
    checkOutput("v_din", 32'(v_din), 32'(mDin));
    checkOutput("clear_busy", 32'(clear_busy), 32'(mBusy));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Random traffic; requests are held stable until accepted.
  task automatic runRandom(input int n, input int clearPct);
    logic          p0 = 1'b0, p1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          cs;
    for (int i = 0; i < n; i++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; a1 = AW'($urandom); d1 = DW'($urandom);
      end
      cs = ($urandom_range(0, 99) < clearPct);
      applyStimulus(p0, a0, d0, p1, a1, d1, cs);
      if (lastWinner == 0) p0 = 1'b0;
      if (lastWinner == 1) p1 = 1'b0;
    end
  endtask

  initial begin
    int busyCycles;
    int k;
    int guard;

    // Reset with random inputs on every port
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0_valid  = 1'($urandom);
      req1_valid  = 1'($urandom);
      req0_addr   = AW'($urandom);
      req1_addr   = AW'($urandom);
      req0_data   = DW'($urandom);
      req1_data   = DW'($urandom);
      clear_start = 1'($urandom);
      @(negedge MEMORY_CLK);
      checkOutput("reset_v_cea", 32'(v_cea), 32'd0);
      checkOutput("reset_v_ada", 32'(v_ada), 32'd0);
      checkOutput("reset_v_din", 32'(v_din), 32'd0);
      checkOutput("reset_clear_busy", 32'(clear_busy), 32'd0);
    end
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    clear_start = 1'b0;
    rst_n       = 1'b1;
    modelReset();
    @(posedge MEMORY_CLK);
    #1;

    // Solo req1 straight after reset is accepted in its first cycle
    applyStimulus(1'b0, '0, '0, 1'b1, 10'h123, 8'h99, 1'b0);
    checkOutput("solo_req1_first_cycle", 32'(lastWinner), 32'd1);

    // Contention: req1 was granted last, so req0, req1, req0, req1
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 10'h010, DW'(8'hA0 + i), 1'b1, 10'h020, DW'(8'hB0 + i), 1'b0);
      checkOutput("contention_order", 32'(lastWinner), 32'(i % 2));
      checkOutput("contention_v_ada", 32'(v_ada), (i % 2 == 0) ? 32'h010 : 32'h020);
    end
    idleCycle();

    // Single CPU write, then the strobe must drop
    applyStimulus(1'b1, 10'h005, 8'h41, 1'b0, '0, '0, 1'b0);
    idleCycle();
    idleCycle();

`ifdef VRAM_ARB_CLEAR_EN
    runRandom(300, 0);

    // Full clear with req0 held valid throughout
    idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    busyCycles = (clear_busy === 1'b1) ? 1 : 0;
    k = 0;
    while (k < WORDS + 50) begin
      applyStimulus(1'b1, 10'h3FF, 8'h55, 1'b0, '0, '0, 1'b0);
      if (lastWinner == 0) break;
      if (clear_busy === 1'b1) busyCycles++;
      k++;
    end
    checkOutput("clear_busy_cycles", 32'(busyCycles), 32'(WORDS));
    checkOutput("held_req0_granted", 32'(lastWinner), 32'd0);
    checkOutput("held_req0_grant_cycle", 32'(k), 32'(WORDS));
    idleCycle();

    // Reset asserted while address 500 is on the port
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    guard = 0;
    while (!(mCea && mAda == 10'd500) && guard < 700) begin
      idleCycle();
      guard++;
    end
    checkOutput("v_ada_before_abort", 32'(v_ada), 32'd500);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_v_cea", 32'(v_cea), 32'd0);
    checkOutput("abort_clear_busy", 32'(clear_busy), 32'd0);
    checkOutput("abort_v_ada", 32'(v_ada), 32'd0);
    @(negedge MEMORY_CLK);
    rst_n = 1'b1;
    modelReset();
    @(posedge MEMORY_CLK);
    #1;
    for (int i = 0; i < 20; i++) idleCycle();
`else
    runRandom(300, 10);

    // Clear pulse is ignored and req1 is granted in the same cycle
    applyStimulus(1'b0, '0, '0, 1'b1, 10'h2AA, 8'h77, 1'b1);
    checkOutput("req1_with_clear_pulse", 32'(req1_ready === 1'b0 ? 0 : 1), 32'd1);
    for (int i = 0; i < 5; i++) idleCycle();
`endif

    runRandom(100, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
